// File: rtl/pc_fetch_unit.sv
// Architectural PC register plus a single-outstanding instruction fetch over imem req/ack.
// Latency: fetch_start -> imem_req next cycle; imem_ack -> ir_valid next cycle (2-cycle minimum).
// Backpressure: imem_req is held until ack or timeout; new requests wait until the fetch retires.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    input  logic        fetch_start,
    input  logic        pc_update,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic        busy,
    output logic [31:0] instr_count,
    output logic        misalign_err,
    output logic        fetch_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2
    } state_t;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic [7:0] tmo_cnt;

    assign imem_addr = pc;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            ir            <= NOP;
            ir_valid      <= 1'b0;
            imem_req      <= 1'b0;
            instr_count   <= 32'd0;
            misalign_err  <= 1'b0;
            fetch_timeout <= 1'b0;
            tmo_cnt       <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    // A fetch request outranks a redirect: it uses the old pc and the redirect is dropped.
                    if (fetch_start) begin
                        if (pc[1:0] == 2'b00) begin
                            state    <= WAIT;
                            imem_req <= 1'b1;
                            tmo_cnt  <= 8'd0;
                        end else begin
                            misalign_err <= 1'b1;
                        end
                    end else if (pc_update) begin
                        pc <= npc;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        ir       <= imem_rdata;
                        ir_valid <= 1'b1;
                        imem_req <= 1'b0;
                        state    <= VALID;
                    end else if (tmo_cnt == TMO_LAST) begin
                        imem_req      <= 1'b0;
                        fetch_timeout <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                VALID: begin
                    if (pc_update) begin
                        pc          <= npc;
                        ir_valid    <= 1'b0;
                        instr_count <= instr_count + 32'd1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed, table-driven checks of pc_fetch_unit plus wait-state and timeout sequences.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] npc = 32'd0;
    logic        fetch_start = 1'b0;
    logic        pc_update = 1'b0;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] ir;
    logic        ir_valid;
    logic        busy;
    logic [31:0] instr_count;
    logic        misalign_err;
    logic        fetch_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .npc(npc), .fetch_start(fetch_start), .pc_update(pc_update),
        .pc(pc), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ir(ir), .ir_valid(ir_valid), .busy(busy),
        .instr_count(instr_count), .misalign_err(misalign_err), .fetch_timeout(fetch_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, fs, pu, ack;
        logic [31:0] npc, rdata;
        logic [31:0] e_pc;
        logic        e_req;
        logic [31:0] e_ir;
        logic        e_irv, e_busy;
        logic [31:0] e_cnt;
        logic        e_mis, e_tmo;
    } vec_t;

    vec_t vecs[22];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then sample 1 time unit later.
    task automatic cyc(input logic r, input logic fs, input logic pu, input logic ack,
                       input logic [31:0] n, input logic [31:0] rd);
        rst = r; fetch_start = fs; pc_update = pu; imem_ack = ack; npc = n; imem_rdata = rd;
        @(posedge clk);
        #1;
    endtask

    int req_cycles;
    logic [31:0] ir_before;

    initial begin
        //            rst fs pu ack npc        rdata         | pc          req ir            irv busy cnt   mis tmo
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0, 32'h0,   32'h0,        32'h0,   1'b0, 32'h00000013, 1'b0,1'b0, 32'd0, 1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b0,1'b0,1'b0, 32'h0,   32'h0,        32'h0,   1'b0, 32'h00000013, 1'b0,1'b0, 32'd0, 1'b0,1'b0};
        vecs[2]  = '{1'b0,1'b1,1'b0,1'b0, 32'h0,   32'h0,        32'h0,   1'b1, 32'h00000013, 1'b0,1'b1, 32'd0, 1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h00500093, 32'h0,   1'b0, 32'h00500093, 1'b1,1'b1, 32'd0, 1'b0,1'b0};
        vecs[4]  = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0,        32'h0,   1'b0, 32'h00500093, 1'b1,1'b1, 32'd0, 1'b0,1'b0};
        vecs[5]  = '{1'b0,1'b0,1'b1,1'b0, 32'h4,   32'h0,        32'h4,   1'b0, 32'h00500093, 1'b0,1'b0, 32'd1, 1'b0,1'b0};
        vecs[6]  = '{1'b0,1'b1,1'b0,1'b0, 32'h0,   32'h0,        32'h4,   1'b1, 32'h00500093, 1'b0,1'b1, 32'd1, 1'b0,1'b0};
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h00a00113, 32'h4,   1'b0, 32'h00a00113, 1'b1,1'b1, 32'd1, 1'b0,1'b0};
        vecs[8]  = '{1'b0,1'b0,1'b1,1'b0, 32'h100, 32'h0,        32'h100, 1'b0, 32'h00a00113, 1'b0,1'b0, 32'd2, 1'b0,1'b0};
        vecs[9]  = '{1'b0,1'b0,1'b0,1'b1, 32'h0,   32'hdeadbeef, 32'h100, 1'b0, 32'h00a00113, 1'b0,1'b0, 32'd2, 1'b0,1'b0};
        vecs[10] = '{1'b0,1'b0,1'b1,1'b0, 32'h6,   32'h0,        32'h6,   1'b0, 32'h00a00113, 1'b0,1'b0, 32'd2, 1'b0,1'b0};
        vecs[11] = '{1'b0,1'b1,1'b0,1'b0, 32'h0,   32'h0,        32'h6,   1'b0, 32'h00a00113, 1'b0,1'b0, 32'd2, 1'b1,1'b0};
        vecs[12] = '{1'b0,1'b1,1'b1,1'b0, 32'h200, 32'h0,        32'h6,   1'b0, 32'h00a00113, 1'b0,1'b0, 32'd2, 1'b1,1'b0};
        vecs[13] = '{1'b0,1'b0,1'b1,1'b0, 32'h8,   32'h0,        32'h8,   1'b0, 32'h00a00113, 1'b0,1'b0, 32'd2, 1'b1,1'b0};
        vecs[14] = '{1'b0,1'b1,1'b0,1'b0, 32'h0,   32'h0,        32'h8,   1'b1, 32'h00a00113, 1'b0,1'b1, 32'd2, 1'b1,1'b0};
        vecs[15] = '{1'b0,1'b1,1'b1,1'b0, 32'h40,  32'h0,        32'h8,   1'b1, 32'h00a00113, 1'b0,1'b1, 32'd2, 1'b1,1'b0};
        vecs[16] = '{1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h12345678, 32'h8,   1'b0, 32'h12345678, 1'b1,1'b1, 32'd2, 1'b1,1'b0};
        vecs[17] = '{1'b0,1'b1,1'b1,1'b0, 32'hc,   32'h0,        32'hc,   1'b0, 32'h12345678, 1'b0,1'b0, 32'd3, 1'b1,1'b0};
        vecs[18] = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0,        32'hc,   1'b0, 32'h12345678, 1'b0,1'b0, 32'd3, 1'b1,1'b0};
        vecs[19] = '{1'b0,1'b1,1'b0,1'b0, 32'h0,   32'h0,        32'hc,   1'b1, 32'h12345678, 1'b0,1'b1, 32'd3, 1'b1,1'b0};
        vecs[20] = '{1'b1,1'b0,1'b0,1'b1, 32'h0,   32'h0badf00d, 32'h0,   1'b0, 32'h00000013, 1'b0,1'b0, 32'd0, 1'b0,1'b0};
        vecs[21] = '{1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h0badf00d, 32'h0,   1'b0, 32'h00000013, 1'b0,1'b0, 32'd0, 1'b0,1'b0};

        for (int i = 0; i < 22; i++) begin
            cyc(vecs[i].rst, vecs[i].fs, vecs[i].pu, vecs[i].ack, vecs[i].npc, vecs[i].rdata);
            chk32($sformatf("v%0d pc", i), pc, vecs[i].e_pc);
            chk32($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_pc);
            chk1($sformatf("v%0d imem_req", i), imem_req, vecs[i].e_req);
            chk32($sformatf("v%0d ir", i), ir, vecs[i].e_ir);
            chk1($sformatf("v%0d ir_valid", i), ir_valid, vecs[i].e_irv);
            chk1($sformatf("v%0d busy", i), busy, vecs[i].e_busy);
            chk32($sformatf("v%0d instr_count", i), instr_count, vecs[i].e_cnt);
            chk1($sformatf("v%0d misalign_err", i), misalign_err, vecs[i].e_mis);
            chk1($sformatf("v%0d fetch_timeout", i), fetch_timeout, vecs[i].e_tmo);
        end

        // Wait states: request held five cycles, ack on the fifth.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        req_cycles = imem_req ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            if (imem_req) req_cycles++;
            chk32($sformatf("ws%0d imem_addr", i), imem_addr, 32'h0);
            chk1($sformatf("ws%0d ir_valid", i), ir_valid, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h00000093);
        chk32("ws req_cycles", 32'(req_cycles), 32'd5);
        chk1("ws imem_req_after", imem_req, 1'b0);
        chk1("ws ir_valid", ir_valid, 1'b1);
        chk32("ws ir", ir, 32'h00000093);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        chk32("ws commit pc", pc, 32'h10);
        chk32("ws commit count", instr_count, 32'd1);

        // Timeout: no ack ever arrives.
        ir_before = 32'h00000093;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        req_cycles = 0;
        for (int i = 0; i < 40 && imem_req; i++) begin
            req_cycles++;
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        chk32("tmo req_cycles", 32'(req_cycles), 32'd16);
        chk1("tmo imem_req", imem_req, 1'b0);
        chk1("tmo fetch_timeout", fetch_timeout, 1'b1);
        chk1("tmo busy", busy, 1'b0);
        chk32("tmo ir", ir, ir_before);
        chk1("tmo ir_valid", ir_valid, 1'b0);
        chk32("tmo pc", pc, 32'h10);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk1("retry imem_req", imem_req, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h00108093);
        chk1("retry ir_valid", ir_valid, 1'b1);
        chk32("retry ir", ir, 32'h00108093);
        chk1("retry fetch_timeout sticky", fetch_timeout, 1'b1);

        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer for the multi-cycle core.
- Consumes the next-PC value produced by the next-PC mux.
- Holds the architectural PC and fetches the word at PC from instruction memory over a req/ack handshake.
- Latches the result into the instruction register for the control FSM.
- Commits the next PC when the control FSM retires the instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, maximum cycles imem_req stays high without imem_ack before the fetch is abandoned. Legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- npc  input  32  next PC from next-PC mux; sampled only on commit.
- fetch_start  input  1  control FSM request to fetch at current pc.
- pc_update  input  1  control FSM commit: pc <= npc.
- pc  output  32  current architectural PC.
- imem_req  output  1  instruction memory request.
- imem_addr  output  32  fetch address; equals pc.
- imem_ack  input  1  memory response valid; imem_rdata is valid in the same cycle.
- imem_rdata  input  32  fetched instruction word.
- ir  output  32  instruction register.
- ir_valid  output  1  ir holds the word fetched from the current pc.
- busy  output  1  high whenever state != IDLE.
- instr_count  output  32  number of committed instructions.
- misalign_err  output  1  sticky: fetch attempted with pc[1:0] != 0.
- fetch_timeout  output  1  sticky: a fetch was abandoned after TIMEOUT_CYCLES.

Behaviour:
- Reset values (synchronous, any state): pc=RESET_PC, ir=32'h0000_0013 (NOP), ir_valid=0, imem_req=0, instr_count=0, misalign_err=0, fetch_timeout=0, timeout counter=0, state=IDLE. Reset during WAIT drops imem_req on the next edge; a late ack after reset is ignored.
- All outputs are registered except imem_addr (=pc) and busy (decoded from state).
- States: IDLE, WAIT, VALID.
- IDLE:
  - fetch_start=1 and pc[1:0]==0 -> WAIT; imem_req=1 from the next cycle; timeout counter cleared.
  - fetch_start=1 and pc[1:0]!=0 -> misalign_err<=1; stay IDLE; no request issued.
  - pc_update=1 -> pc<=npc. No count increment; this is a redirect without execute.
  - fetch_start and pc_update together: the fetch uses the old pc, and pc<=npc is suppressed.
- WAIT:
  - imem_req held high; pc and imem_addr held stable.
  - imem_ack=1 -> ir<=imem_rdata, ir_valid<=1, imem_req<=0, state -> VALID. An ack in the first cycle req is high is accepted.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 without ack -> imem_req<=0, fetch_timeout<=1, state -> IDLE; ir and ir_valid unchanged (ir_valid=0).
  - fetch_start and pc_update are ignored in WAIT.
- VALID:
  - ir and ir_valid=1 held until commit.
  - pc_update=1 -> pc<=npc, ir_valid<=0, instr_count<=instr_count+1 (wraps modulo 2^32), state -> IDLE.
  - fetch_start is ignored in VALID, even when coincident with pc_update; the FSM must re-issue it in IDLE.
- imem_ack outside WAIT is ignored.
- Latency:
  - fetch_start at cycle t -> imem_req high at t+1.
  - ack at cycle t+k (k>=1) -> ir_valid high at t+k+1.
  - Minimum fetch is 2 cycles from start to ir_valid.
- misalign_err and fetch_timeout clear only on rst.

Test Plan:
1. Reset then basic fetch: rst 2 cycles -> pc=0, ir=0x00000013, ir_valid=0. fetch_start at t; ack with rdata=0x00500093 at t+1 -> imem_req high at t+1 only, ir=0x00500093, ir_valid=1 at t+2.
2. Commit and next fetch: in VALID, pc_update with npc=0x4 -> pc=0x4, instr_count=1, ir_valid=0. Next fetch shows imem_addr=0x4. Repeat with npc=0x100 -> pc=0x100, instr_count=2.
3. Wait states: ack delayed 5 cycles -> imem_req high exactly 5 cycles, imem_addr stable, ir_valid rises the cycle after ack.
4. Timeout: never ack with TIMEOUT_CYCLES=16 -> imem_req high 16 cycles then low, fetch_timeout=1, state IDLE, ir unchanged. A later fetch with ack succeeds; fetch_timeout stays 1.
5. Misalignment: IDLE pc_update npc=0x6, then fetch_start -> pc=0x6, misalign_err=1, imem_req never asserted.
6. Reset mid-fetch and stray ack: rst asserted during WAIT -> next cycle imem_req=0, pc=RESET_PC; ack arriving after reset is ignored (ir stays 0x00000013). Ack pulse in IDLE -> no change. Simultaneous fetch_start+pc_update in VALID -> pc updated, no request issued.
